ddr_responder: RTL and testbench

- Memory-side responder for the core's DDR channel: accepts requests issued by the channel arbiter and performs line (burst) or 64-bit (single) reads and writes against an internal backing store.
- Returns read data with a one-cycle ddr_operation_done pulse after a parameterised latency.
- Sits outside the core, directly on the ddr_* port set; used as the synthesizable memory model for simulation and FPGA bring-up.

---
 rtl/ddr_responder.sv | 114 +++++++++++
 tb/tb_ddr_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_responder.sv
// Memory-side DDR responder: a line-organised backing store that serves burst
// and 64-bit single reads/writes and pulses ddr_operation_done after a fixed latency.
module ddr_responder #(
  parameter int LINE_ADDR_WIDTH = 10,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ddr_chip_enable,
  input  logic [63:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [511:0] ddr_write_mask,
  input  logic [511:0] ddr_write_data,
  output logic [511:0] ddr_read_data,
  output logic         ddr_operation_done,
  output logic         ddr_ready
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int DEPTH   = 2 ** LINE_ADDR_WIDTH;
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_count;
  logic [511:0]               r_result;
  logic [511:0]               r_store [DEPTH];

  logic [LINE_ADDR_WIDTH-1:0] w_line;
  logic [2:0]                 w_lane;
  logic [8:0]                 w_shift;
  logic [511:0]               w_lineData;
  logic [63:0]                w_laneData;
  logic [511:0]               w_effMask;
  logic [511:0]               w_effData;
  logic [511:0]               w_readValue;
  logic [CW-1:0]              w_load;
  logic                       w_accept;
  logic                       w_unused;

  assign w_line      = ddr_index[LINE_ADDR_WIDTH+5:6];
  assign w_lane      = ddr_index[5:3];
  assign w_shift     = {w_lane, 6'd0};
  assign w_lineData  = r_store[w_line];
  assign w_laneData  = w_lineData[w_shift +: 64];
  assign w_effMask   = ddr_burst_mode ? ddr_write_mask : ({448'b0, ddr_write_mask[63:0]} << w_shift);
  assign w_effData   = ddr_burst_mode ? ddr_write_data : ({448'b0, ddr_write_data[63:0]} << w_shift);
  assign w_readValue = ddr_burst_mode ? w_lineData : {448'b0, w_laneData};
  assign w_load      = ddr_write_enable ? WR_LOAD : RD_LOAD;
  assign w_accept    = ddr_chip_enable && ddr_ready && !reset;
  assign w_unused    = ^{ddr_index[63:LINE_ADDR_WIDTH+6], ddr_index[2:0]};

  // Store contents survive reset; a write lands in full at its accept edge.
  always_ff @(posedge clock) begin
    if (w_accept && ddr_write_enable)
      r_store[w_line] <= (w_lineData & ~w_effMask) | (w_effData & w_effMask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= IDLE;
      r_count            <= '0;
      r_result           <= '0;
      ddr_read_data      <= '0;
      ddr_operation_done <= 1'b0;
      ddr_ready          <= 1'b1;
    end else begin
      ddr_operation_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count   <= w_load;
            ddr_ready <= 1'b0;
            if (!ddr_write_enable)
              r_result <= w_readValue;
            // A one-cycle latency skips BUSY, so the result must bypass r_result.
            if (w_load == '0) begin
              r_state            <= DONE;
              ddr_operation_done <= 1'b1;
              if (!ddr_write_enable)
                ddr_read_data <= w_readValue;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_count == CW'(1)) begin
            r_state            <= DONE;
            r_count            <= '0;
            ddr_operation_done <= 1'b1;
            ddr_read_data      <= r_result;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        DONE: begin
          r_state   <= IDLE;
          ddr_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          ddr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_responder.sv
// Self-checking bench for ddr_responder: directed steps plus randomized traffic
// checked against a line-level reference model of the backing store.
module tb_ddr_responder;

  localparam int LAW = 10;
  localparam int RL  = 4;
  localparam int WL  = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ddr_chip_enable = 1'b0;
  logic [63:0]  ddr_index = '0;
  logic         ddr_write_enable = 1'b0;
  logic         ddr_burst_mode = 1'b0;
  logic [511:0] ddr_write_mask = '0;
  logic [511:0] ddr_write_data = '0;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  logic [511:0] model [int];
  logic [511:0] lastRead = '0;
  logic [511:0] allOnes = '1;

  ddr_responder #(
    .LINE_ADDR_WIDTH(LAW),
    .READ_LATENCY(RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ddr_chip_enable(ddr_chip_enable),
    .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable),
    .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_mask(ddr_write_mask),
    .ddr_write_data(ddr_write_data),
    .ddr_read_data(ddr_read_data),
    .ddr_operation_done(ddr_operation_done),
    .ddr_ready(ddr_ready)
  );

  always #5 clock = ~clock;

  // Counts every completion pulse so stray or missing pulses can be detected.
  always @(posedge clock) begin
    if (ddr_operation_done === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] randWide();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int lineOf(input logic [63:0] idx);
    return int'((idx / 64) % (2 ** LAW));
  endfunction

  function automatic logic [511:0] modelLine(input int line);
    if (model.exists(line)) return model[line];
    return '0;
  endfunction

  // Waits for the completion pulse after an accept; returns edges elapsed after the accept edge.
  task automatic waitDone(input string tag, output int k);
    k = 0;
    while (ddr_operation_done !== 1'b1 && k < 20) begin
      checkOutput({tag, "_busyReady"}, {511'b0, ddr_ready}, 512'd0);
      @(negedge clock);
      k++;
    end
  endtask

  task automatic applyStimulus(input bit we, input bit burst, input logic [63:0] idx,
                               input logic [511:0] mask, input logic [511:0] data,
                               input string tag);
    int line, lane, k;
    logic [511:0] old, expRead;
    line = lineOf(idx);
    lane = int'((idx / 8) % 8);
    old  = modelLine(line);
    if (!we) begin
      expRead = burst ? old : {448'b0, old[lane*64 +: 64]};
    end else begin
      expRead = lastRead;
      if (burst) begin
        model[line] = (old & ~mask) | (data & mask);
      end else begin
        for (int b = 0; b < 64; b++)
          if (mask[b]) old[lane*64 + b] = data[b];
        model[line] = old;
      end
    end
    @(negedge clock);
    checkOutput({tag, "_readyBefore"}, {511'b0, ddr_ready}, 512'd1);
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = we;
    ddr_burst_mode   = burst;
    ddr_index        = idx;
    ddr_write_mask   = mask;
    ddr_write_data   = data;
    @(posedge clock);
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    waitDone(tag, k);
    checkOutput({tag, "_latency"}, 512'(k), 512'((we ? WL : RL) - 1));
    checkOutput({tag, "_data"}, ddr_read_data, expRead);
    lastRead = expRead;
    @(negedge clock);
    checkOutput({tag, "_donePulse"}, {511'b0, ddr_operation_done}, 512'd0);
    checkOutput({tag, "_readyAfter"}, {511'b0, ddr_ready}, 512'd1);
  endtask

  initial begin
    int k, startDone;
    logic [511:0] expRead;

    $display("[TB] reset and idle checks");
    reset = 1'b1;
    #12;
    checkOutput("reset_ready", {511'b0, ddr_ready}, 512'd1);
    checkOutput("reset_done", {511'b0, ddr_operation_done}, 512'd0);
    checkOutput("reset_data", ddr_read_data, 512'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle_ready", {511'b0, ddr_ready}, 512'd1);
    checkOutput("idle_noDone", 512'(doneCount), 512'd0);

    $display("[TB] burst write then read");
    applyStimulus(1, 1, 64'h40, allOnes, {64{8'hA5}}, "burstWr");
    applyStimulus(0, 1, 64'h40, '0, '0, "burstRd");
    checkOutput("burstRd_pattern", ddr_read_data, {64{8'hA5}});

    $display("[TB] single masked write");
    applyStimulus(1, 1, 64'h80, allOnes, '0, "preload");
    applyStimulus(1, 0, 64'h98, {448'b0, 64'h0000_0000_FFFF_FFFF}, {448'b0, 64'hDEADBEEF_CAFEF00D}, "singleWr");
    applyStimulus(0, 0, 64'h98, '0, '0, "singleRd");
    checkOutput("singleRd_value", ddr_read_data, {448'b0, 64'h00000000_CAFEF00D});
    applyStimulus(0, 1, 64'h80, '0, '0, "lineRd");
    checkOutput("lineRd_value", ddr_read_data, {288'b0, 32'hCAFEF00D, 192'b0});

    $display("[TB] request while busy");
    startDone = doneCount;
    expRead   = modelLine(1);
    @(negedge clock);
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b1;
    ddr_index        = 64'h40;
    @(posedge clock);
    @(negedge clock);
    ddr_write_enable = 1'b1;
    ddr_write_mask   = allOnes;
    ddr_write_data   = randWide();
    @(negedge clock);
    ddr_chip_enable  = 1'b0;
    ddr_write_enable = 1'b0;
    waitDone("busyRd", k);
    checkOutput("busyRd_latency", 512'(k + 1), 512'(RL - 1));
    checkOutput("busyRd_data", ddr_read_data, expRead);
    lastRead = expRead;
    repeat (4) @(negedge clock);
    checkOutput("busy_onePulse", 512'(doneCount - startDone), 512'd1);
    applyStimulus(0, 1, 64'h40, '0, '0, "busyUnchanged");

    $display("[TB] address wrap");
    applyStimulus(1, 1, 64'h10040, allOnes, randWide(), "wrapWr");
    applyStimulus(0, 1, 64'h40, '0, '0, "wrapRd");

    $display("[TB] reset mid-operation");
    startDone = doneCount;
    @(negedge clock);
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b1;
    ddr_index        = 64'h80;
    @(posedge clock);
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midReset_ready", {511'b0, ddr_ready}, 512'd1);
    checkOutput("midReset_done", {511'b0, ddr_operation_done}, 512'd0);
    checkOutput("midReset_data", ddr_read_data, 512'd0);
    lastRead = '0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checkOutput("midReset_noPulse", 512'(doneCount - startDone), 512'd0);
    applyStimulus(0, 1, 64'h80, '0, '0, "postReset");

    $display("[TB] randomized traffic");
    for (int l = 0; l < 8; l++)
      applyStimulus(1, 1, 64'(l * 64), allOnes, randWide(), "init");
    for (int i = 0; i < 30; i++) begin
      logic [63:0] idx;
      bit we, burst;
      idx   = {32'($urandom), 32'($urandom)};
      idx[15:6] = 10'($urandom_range(0, 7));
      we    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      applyStimulus(we, burst, idx, randWide(), randWide(), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
